ezrisc_alu: RTL and testbench
=============================

Name: ezrisc_alu

Overview:
- Registered 32-bit integer ALU for the ezRISC datapath; executes one operation per cycle selected by a 4-bit control code.
- Produces a 64-bit result so the full signed product fits; 32-bit ops occupy the low word.
- Sits between register-file read and writeback; one-cycle latency.

Parameters:
- None; data width fixed at 32, result width 64.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands/control valid this cycle
- ALU_ctrl  input  4  operation select
- A  input  32  operand A
- B  input  32  operand B
- result  output  64  registered result
- zero  output  1  registered; 1 when result == 0
- out_valid  output  1  registered; result updated this cycle

Behaviour:
- Reset, sampled on clk rising edge with reset_n=0: result=0, zero=0, out_valid=0. Reset overrides in_valid on the same edge.
- Latency: in_valid=1 at edge N -> result, zero and out_valid=1 visible after edge N.
- in_valid=0 at an edge: out_valid=0; result and zero hold their previous values.
- No backpressure; one new operation is accepted every cycle.
- Width rule: unless stated otherwise, 32-bit results go in result[31:0] and result[63:32]=0.
- ALU_ctrl encoding:
  - 0x0 ADD: [31:0]=A+B mod 2^32; result[32]=carry-out; [63:33]=0.
  - 0x1 SUB: [31:0]=A-B mod 2^32; result[32]=borrow (A<B unsigned); [63:33]=0.
  - 0x2 AND; 0x3 OR; 0x4 XOR: bitwise on 32 bits.
  - 0x5 NOR: ~(A|B) on 32 bits.
  - 0x6 SLL: A << B[4:0].
  - 0x7 SRL: A >> B[4:0], logical.
  - 0x8 SRA: A >>> B[4:0], arithmetic.
  - 0x9 SLT: 1 if signed A < signed B, else 0.
  - 0xA SLTU: 1 if unsigned A < unsigned B, else 0.
  - 0xB MUL: full signed 32x32 -> 64-bit product in result[63:0].
  - 0xC-0xF: result=0, unless enabled by the optional feature.
- Shifts ignore B[31:5]; a shift amount of 0 passes A unchanged.
- zero is computed from the full 64-bit next result.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: 0xC DIV, signed. result[31:0]=quotient truncated toward zero; result[63:32]=remainder with the sign of A.
  - B=0: quotient=0xFFFFFFFF, remainder=A.
  - A=0x80000000, B=0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Latency stays one cycle (combinational divider).
- Undefined: 0xC returns result=0 like 0xD-0xF; no divider logic is synthesized.

Test Plan:
- Reset: reset_n=0 for 2 cycles with in_valid=1 -> result=0, zero=0, out_valid=0.
- A=0xB5, B=0xD, ctrl 0x0..0x5 -> result 0xC2, 0xA8, 0x05, 0xBD, 0xB8, 0x00000000FFFFFF42 respectively.
- A=0xB5, B=0xD, ctrl 0x6..0xB -> 0x16A000, 0x0, 0x0, 0x0, 0x0, 0x931.
  - SRL and SRA give zero=1; SLT and SLTU are 0 because 181 > 13.
- A=B=0xFFFFFFFF:
  - ADD -> 0x1FFFFFFFE.
  - SUB -> 0, zero=1.
  - MUL -> 0x1.
  - SLT -> 0.
  - SRA with B[4:0]=31 -> 0xFFFFFFFF.
- A=0x80000000, B=0x1: SLT -> 1, SLTU -> 0, MUL -> 0xFFFFFFFF80000000, SUB -> 0x7FFFFFFF with result[32]=0.
- Handshake: in_valid=0 for one cycle mid-stream -> out_valid=0 and result holds. Then with ALU_DIV_EN defined, ctrl 0xC, A=7, B=0 -> result 0x00000007FFFFFFFF; undefined -> result=0.

Source files
------------

// File: rtl/ezrisc_alu_if.sv
// Operand/result bundle for the ezRISC ALU.
// The driver presents operands with in_valid; the ALU answers one cycle later with out_valid.
interface ezrisc_alu_if;
  logic        in_valid;
  logic [3:0]  ALU_ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] result;
  logic        zero;
  logic        out_valid;

  modport master (
    output in_valid, ALU_ctrl, A, B,
    input  result, zero, out_valid
  );

  modport slave (
    input  in_valid, ALU_ctrl, A, B,
    output result, zero, out_valid
  );
endinterface

// File: rtl/ezrisc_alu.sv
// Registered 32-bit ALU with 64-bit result, one-cycle latency.
// Optional signed divide on ctrl 0xC is enabled by defining ALU_DIV_EN.
module ezrisc_alu (
  input  logic         clk,
  input  logic         reset_n,
  ezrisc_alu_if.slave  bus
);
  // Handshake: in_valid=1 at edge N yields out_valid=1 with the new result
  // after edge N. There is no ready; every valid operation is accepted.
  // Idle cycles drop out_valid and hold result/zero.

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [32:0] sum33;
  logic [32:0] diff33;
  logic [31:0] sra_val;
  logic signed [63:0] prod;
  logic [63:0] next_result;

  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = b[4:0];

  // 33-bit add/sub: bit 32 is carry-out for ADD and unsigned borrow for SUB.
  assign sum33   = {1'b0, a} + {1'b0, b};
  assign diff33  = {1'b0, a} - {1'b0, b};
  assign sra_val = $signed(a) >>> shamt;
  assign prod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

`ifdef ALU_DIV_EN
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] quo;
  logic signed [31:0] rem;

  assign sa = a;
  assign sb = b;

  // Divide-by-zero and the single overflow case are pinned explicitly.
  always_comb begin
    quo = '0;
    rem = '0;
    if (b == 32'h0) begin
      quo = 32'hFFFF_FFFF;
      rem = sa;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = '0;
    end else begin
      quo = sa / sb;
      rem = sa % sb;
    end
  end
`endif

  always_comb begin
    next_result = '0;
    case (bus.ALU_ctrl)
      4'h0: next_result = {31'b0, sum33};
      4'h1: next_result = {31'b0, diff33};
      4'h2: next_result = {32'b0, a & b};
      4'h3: next_result = {32'b0, a | b};
      4'h4: next_result = {32'b0, a ^ b};
      4'h5: next_result = {32'b0, ~(a | b)};
      4'h6: next_result = {32'b0, a << shamt};
      4'h7: next_result = {32'b0, a >> shamt};
      4'h8: next_result = {32'b0, sra_val};
      4'h9: next_result = {63'b0, ($signed(a) < $signed(b))};
      4'hA: next_result = {63'b0, (a < b)};
      4'hB: next_result = prod;
`ifdef ALU_DIV_EN
      4'hC: next_result = {rem, quo};
`endif
      default: next_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result <= next_result;
        bus.zero   <= (next_result == 64'h0);
      end
    end
  end
endmodule

// File: tb/tb_ezrisc_alu.sv
// Directed-vector scoreboard bench for ezrisc_alu; expected values are hand-computed.
// Build with ALU_DIV_EN defined to exercise the divide vectors.
module tb_ezrisc_alu;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [64:0] exp_q[$];
  string       name_q[$];
  logic [63:0] last_exp;

  ezrisc_alu_if bus ();

  ezrisc_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic issue(input string name, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = ctrl;
    bus.A        = a;
    bus.B        = b;
    exp_q.push_back({(exp == 64'h0), exp});
    name_q.push_back(name);
    last_exp = exp;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.ALU_ctrl = 4'h0;
    bus.A        = 32'hDEAD_BEEF;
    bus.B        = 32'h1234_5678;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per out_valid
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: result=%h with no pending op", bus.result);
      end else begin
        logic [64:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.result !== e[63:0] || bus.zero !== e[64]) begin
          bad++;
          $display("FAIL %s: got result=%h zero=%b, want result=%h zero=%b",
                   n, bus.result, bus.zero, e[63:0], e[64]);
        end
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    last_exp = '0;
    reset_n  = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = 4'h0;
    bus.A        = 32'h1;
    bus.B        = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.result !== 64'h0 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL reset: got out_valid=%b result=%h zero=%b, want 0/0/0",
               bus.out_valid, bus.result, bus.zero);
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Small operands, every opcode
    issue("add_b5_d",  4'h0, 32'hB5, 32'hD, 64'hC2);
    issue("sub_b5_d",  4'h1, 32'hB5, 32'hD, 64'hA8);
    issue("and_b5_d",  4'h2, 32'hB5, 32'hD, 64'h05);
    issue("or_b5_d",   4'h3, 32'hB5, 32'hD, 64'hBD);
    issue("xor_b5_d",  4'h4, 32'hB5, 32'hD, 64'hB8);
    issue("nor_b5_d",  4'h5, 32'hB5, 32'hD, 64'h0000_0000_FFFF_FF42);
    issue("sll_b5_d",  4'h6, 32'hB5, 32'hD, 64'h16A000);
    issue("srl_b5_d",  4'h7, 32'hB5, 32'hD, 64'h0);
    issue("sra_b5_d",  4'h8, 32'hB5, 32'hD, 64'h0);
    issue("slt_b5_d",  4'h9, 32'hB5, 32'hD, 64'h0);
    issue("sltu_b5_d", 4'hA, 32'hB5, 32'hD, 64'h0);
    issue("mul_b5_d",  4'hB, 32'hB5, 32'hD, 64'h931);

    // All-ones operands
    issue("add_ff",    4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_FFFF_FFFE);
    issue("sub_ff",    4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    issue("mul_ff",    4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
    issue("slt_ff",    4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    issue("sra_ff_31", 4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF);

    // Sign boundary
    issue("slt_min_1",  4'h9, 32'h8000_0000, 32'h1, 64'h1);
    issue("sltu_min_1", 4'hA, 32'h8000_0000, 32'h1, 64'h0);
    issue("mul_min_1",  4'hB, 32'h8000_0000, 32'h1, 64'hFFFF_FFFF_8000_0000);
    issue("sub_min_1",  4'h1, 32'h8000_0000, 32'h1, 64'h7FFF_FFFF);
    issue("sra_min_1",  4'h8, 32'h8000_0000, 32'h1, 64'hC000_0000);
    issue("srl_min_1",  4'h7, 32'h8000_0000, 32'h1, 64'h4000_0000);

    // Shift amount 0 (upper B bits ignored), borrow, SLTU true, unused codes
    issue("sll_sh0",    4'h6, 32'h1234_5678, 32'h20, 64'h1234_5678);
    issue("sub_borrow", 4'h1, 32'h1, 32'h2, 64'h1_FFFF_FFFF);
    issue("sltu_1_2",   4'hA, 32'h1, 32'h2, 64'h1);
    issue("op_d",       4'hD, 32'hB5, 32'hD, 64'h0);
    issue("op_f",       4'hF, 32'hFFFF_FFFF, 32'h1, 64'h0);
    issue("or_last",    4'h3, 32'hA000_0000, 32'h5, 64'hA000_0005);

    // Mid-stream bubble: out_valid drops, result/zero hold
    idle_cycle();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.result !== last_exp || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: got out_valid=%b result=%h zero=%b, want 0/%h/0",
               bus.out_valid, bus.result, bus.zero, last_exp);
    end
    @(posedge clk);
    #1;

`ifdef ALU_DIV_EN
    issue("div_7_0",    4'hC, 32'h7, 32'h0, 64'h0000_0007_FFFF_FFFF);
    issue("div_b5_d",   4'hC, 32'hB5, 32'hD, 64'h0000_000C_0000_000D);
    issue("div_ovf",    4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    issue("div_m7_2",   4'hC, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    issue("div_7_0",    4'hC, 32'h7, 32'h0, 64'h0);
    issue("div_b5_d",   4'hC, 32'hB5, 32'hD, 64'h0);
`endif

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle_cycle();
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending ops, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
